// File: rtl/mem_bus_responder.sv
// mem_bus_responder
//
// Memory-side responder for the CPU external bus. It holds a DEPTH x DATA_W
// synchronous word memory. Bus reads and writes use a level req / one-cycle
// ack handshake, with WAIT_CYCLES wait states between accepting a request and
// the ack. A program-loader port streams words into consecutive addresses,
// starting from address 0, before the CPU is started.
//
// Ports:
//   i_clk, i_rst        rising-edge clock; synchronous active-high reset
//   i_mem_addr          word address (MAR path)
//   i_mem_data          write data (MBR path)
//   i_rd_req, i_wr_req  level requests, held until o_ack; write wins if both
//   o_mem_data          read data; valid while o_ack=1, then held until next read ack
//   o_ack               one-cycle completion pulse
//   o_busy              high in any state other than IDLE
//   i_load_en           loader mode request (has priority over bus requests in IDLE)
//   i_load_valid        loader word valid
//   i_load_data         loader word
//   o_load_ready        loader may present a word (in LOAD and not yet full)
//   o_load_count        words written since entering LOAD (one bit wider than the address)
//   o_load_full         sticky, set once DEPTH words have been loaded
module mem_bus_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic              i_rd_req,
  input  logic              i_wr_req,
  output logic [DATA_W-1:0] o_mem_data,
  output logic              o_ack,
  output logic              o_busy,
  input  logic              i_load_en,
  input  logic              i_load_valid,
  input  logic [DATA_W-1:0] i_load_data,
  output logic              o_load_ready,
  output logic [ADDR_W:0]   o_load_count,
  output logic              o_load_full
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [3:0]       WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_ACK,
    ST_LOAD
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic                wr_reg, wr_next;
  logic [3:0]          wait_reg, wait_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic                full_reg, full_next;
  logic [DATA_W-1:0]   rd_data_reg;

  logic                load_fire;
  logic                rd_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  // Word memory. Contents are deliberately not touched by reset so a loaded
  // program survives a CPU reset.
  logic [DATA_W-1:0]   mem [DEPTH];

  // Next-state and datapath control
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    wr_next    = wr_reg;
    wait_next  = wait_reg;
    count_next = count_reg;
    full_next  = full_reg;
    load_fire  = 1'b0;
    rd_en      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (i_load_en) begin
          state_next = ST_LOAD;
          count_next = '0;
          full_next  = 1'b0;
        end else if (i_wr_req || i_rd_req) begin
          addr_next = i_mem_addr;
          data_next = i_mem_data;
          wr_next   = i_wr_req;  // a simultaneous read is dropped
          wait_next = WAIT_INIT;
          if (WAIT_CYCLES == 0) begin
            state_next = ST_ACK;
            // Read data must be on o_mem_data during the ACK cycle, so the
            // synchronous read is issued on the edge that enters ACK.
            rd_en      = ~i_wr_req;
          end else begin
            state_next = ST_ACCESS;
          end
        end
      end

      ST_ACCESS: begin
        // The counter is loaded with WAIT_CYCLES, so ACCESS lasts exactly
        // WAIT_CYCLES cycles. The guard keeps it from wrapping below zero.
        if (wait_reg > 4'd1) begin
          wait_next = wait_reg - 4'd1;
        end else begin
          wait_next  = '0;
          state_next = ST_ACK;
          rd_en      = ~wr_reg;
        end
      end

      ST_ACK: begin
        state_next = ST_IDLE;
      end

      ST_LOAD: begin
        // Once full, no more words are accepted, so the count never wraps
        // and no address is overwritten.
        if (i_load_valid && !full_reg) begin
          load_fire  = 1'b1;
          count_next = count_reg + CNT_W'(1);
          if (count_reg == LOAD_LAST) begin
            full_next = 1'b1;
          end
        end
        if (!i_load_en) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      data_reg  <= '0;
      wr_reg    <= 1'b0;
      wait_reg  <= '0;
      count_reg <= '0;
      full_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      wr_reg    <= wr_next;
      wait_reg  <= wait_next;
      count_reg <= count_next;
      full_reg  <= full_next;
    end
  end

  // Single write port shared by the bus (commit at the end of ACK) and the
  // loader. Both can never happen in the same cycle because they come from
  // different states.
  assign mem_we    = ((state_reg == ST_ACK) && wr_reg) || load_fire;
  assign mem_waddr = load_fire ? count_reg[ADDR_W-1:0] : addr_reg;
  assign mem_wdata = load_fire ? i_load_data : data_reg;

  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read port. It updates only on a read entering ACK and holds
  // its value otherwise, so writes never disturb o_mem_data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= mem[addr_next];
    end
  end

  assign o_mem_data   = rd_data_reg;
  assign o_ack        = (state_reg == ST_ACK);
  assign o_busy       = (state_reg != ST_IDLE);
  assign o_load_ready = (state_reg == ST_LOAD) && !full_reg;
  assign o_load_count = count_reg;
  assign o_load_full  = full_reg;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed testbench for mem_bus_responder with WAIT_CYCLES=1.
// Inputs are driven on the falling edge and outputs are sampled on the
// falling edge, away from the active rising edge.
module tb_mem_bus_responder;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int WAIT   = 1;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [ADDR_W-1:0] i_mem_addr;
  logic [DATA_W-1:0] i_mem_data;
  logic              i_rd_req;
  logic              i_wr_req;
  logic [DATA_W-1:0] o_mem_data;
  logic              o_ack;
  logic              o_busy;
  logic              i_load_en;
  logic              i_load_valid;
  logic [DATA_W-1:0] i_load_data;
  logic              o_load_ready;
  logic [ADDR_W:0]   o_load_count;
  logic              o_load_full;

  int n_tests = 0;
  int n_fail  = 0;

  mem_bus_responder #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .WAIT_CYCLES(WAIT)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_mem_addr  (i_mem_addr),
    .i_mem_data  (i_mem_data),
    .i_rd_req    (i_rd_req),
    .i_wr_req    (i_wr_req),
    .o_mem_data  (o_mem_data),
    .o_ack       (o_ack),
    .o_busy      (o_busy),
    .i_load_en   (i_load_en),
    .i_load_valid(i_load_valid),
    .i_load_data (i_load_data),
    .o_load_ready(o_load_ready),
    .o_load_count(o_load_count),
    .o_load_full (o_load_full)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Issue one bus request from a falling edge. Returns the number of falling
  // edges after the sampling edge at which o_ack was seen (-1 on timeout)
  // and the o_mem_data value seen with the ack. Also checks that the ack
  // lasts one cycle only. Returns on a falling edge.
  task automatic bus_op(input logic wr, input logic rd, input logic [7:0] addr,
                        input logic [15:0] data, input string tag,
                        output int lat, output logic [15:0] rdata);
    i_wr_req   = wr;
    i_rd_req   = rd;
    i_mem_addr = addr;
    i_mem_data = data;
    lat   = -1;
    rdata = '0;
    @(posedge i_clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge i_clk);
      if (o_ack) begin
        lat   = k;
        rdata = o_mem_data;
        break;
      end
    end
    i_wr_req = 1'b0;
    i_rd_req = 1'b0;
    @(negedge i_clk);
    check({tag, "_ack_width"}, {31'd0, o_ack}, 32'd0);
  endtask

  // Count the acks seen over n falling edges.
  task automatic count_acks(input int n, output int acks);
    acks = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge i_clk);
      if (o_ack) acks++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int acks;
    logic [15:0] rdata;

    i_rst = 1'b1; i_mem_addr = '0; i_mem_data = '0; i_rd_req = 1'b0; i_wr_req = 1'b0;
    i_load_en = 1'b0; i_load_valid = 1'b0; i_load_data = '0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;

    // 1. Data written before reset survives it; outputs clear.
    bus_op(1'b1, 1'b0, 8'h40, 16'h5A5A, "pre_wr", lat, rdata);
    bus_op(1'b0, 1'b1, 8'h40, 16'h0000, "pre_rd", lat, rdata);
    check("pre_rd_data", {16'd0, rdata}, 32'h5A5A);
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_mem_data",   {16'd0, o_mem_data}, 32'd0);
    check("rst_ack",        {31'd0, o_ack}, 32'd0);
    check("rst_busy",       {31'd0, o_busy}, 32'd0);
    check("rst_load_ready", {31'd0, o_load_ready}, 32'd0);
    check("rst_load_count", {23'd0, o_load_count}, 32'd0);
    check("rst_load_full",  {31'd0, o_load_full}, 32'd0);
    i_rst = 1'b0;
    bus_op(1'b0, 1'b1, 8'h40, 16'h0000, "post_rst_rd", lat, rdata);
    check("post_rst_rd_lat",  lat, 32'(1 + WAIT));
    check("post_rst_rd_data", {16'd0, rdata}, 32'h5A5A);

    // 2. Write then read back, latency 1+WAIT.
    bus_op(1'b1, 1'b0, 8'h10, 16'hBEEF, "wr10", lat, rdata);
    check("wr10_lat", lat, 32'(1 + WAIT));
    bus_op(1'b0, 1'b1, 8'h10, 16'h0000, "rd10", lat, rdata);
    check("rd10_lat",  lat, 32'(1 + WAIT));
    check("rd10_data", {16'd0, rdata}, 32'hBEEF);

    // 3. Read and write together: write wins, one ack, o_mem_data untouched.
    bus_op(1'b1, 1'b1, 8'h20, 16'h1234, "both20", lat, rdata);
    check("both20_lat",  lat, 32'(1 + WAIT));
    check("both20_data", {16'd0, rdata}, 32'hBEEF);
    count_acks(5, acks);
    check("both20_extra_acks", acks, 32'd0);
    bus_op(1'b0, 1'b1, 8'h20, 16'h0000, "rd20", lat, rdata);
    check("rd20_data", {16'd0, rdata}, 32'h1234);

    // 4. Loader fills all 256 words; a 257th is ignored.
    i_load_en = 1'b1;
    @(negedge i_clk);
    check("load_busy",  {31'd0, o_busy}, 32'd1);
    check("load_ready", {31'd0, o_load_ready}, 32'd1);
    check("load_count0", {23'd0, o_load_count}, 32'd0);
    for (int k = 0; k < 256; k++) begin
      i_load_valid = 1'b1;
      i_load_data  = 16'hA000 + 16'(k);
      @(negedge i_clk);
    end
    i_load_data = 16'hDEAD;
    check("load_count_full", {23'd0, o_load_count}, 32'd256);
    check("load_full",       {31'd0, o_load_full}, 32'd1);
    check("load_ready_full", {31'd0, o_load_ready}, 32'd0);
    @(negedge i_clk);
    check("load_count_257", {23'd0, o_load_count}, 32'd256);
    i_load_valid = 1'b0;

    // 5. A read during LOAD waits until LOAD exits.
    i_rd_req   = 1'b1;
    i_mem_addr = 8'hFF;
    count_acks(4, acks);
    check("load_rd_no_ack", acks, 32'd0);
    i_load_en = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge i_clk);
      if (o_ack) begin
        lat   = k;
        rdata = o_mem_data;
        break;
      end
    end
    i_rd_req = 1'b0;
    check("load_exit_rd_lat",  lat, 32'(2 + WAIT));
    check("load_exit_rd_data", {16'd0, rdata}, 32'hA0FF);
    check("load_count_held", {23'd0, o_load_count}, 32'd256);
    check("load_full_held",  {31'd0, o_load_full}, 32'd1);
    @(negedge i_clk);
    bus_op(1'b0, 1'b1, 8'h00, 16'h0000, "rd00", lat, rdata);
    check("rd00_data", {16'd0, rdata}, 32'hA000);

    // 6. Reset during ACCESS of a write: no ack, old contents kept.
    i_wr_req   = 1'b1;
    i_mem_addr = 8'h30;
    i_mem_data = 16'h7777;
    @(posedge i_clk);
    @(negedge i_clk);
    check("abort_in_access", {31'd0, o_busy}, 32'd1);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("abort_ack",  {31'd0, o_ack}, 32'd0);
    check("abort_busy", {31'd0, o_busy}, 32'd0);
    i_rst    = 1'b0;
    i_wr_req = 1'b0;
    count_acks(4, acks);
    check("abort_no_ack", acks, 32'd0);
    bus_op(1'b0, 1'b1, 8'h30, 16'h0000, "rd30", lat, rdata);
    check("rd30_data", {16'd0, rdata}, 32'hA030);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
